// File: rtl/led_flasher.sv
// Timed active-low flasher: a start pulse runs `count` ON/OFF phases on out_n_o.
// Optional LED_FLASHER_RETRIG_EN lets a start while busy restart or abort the sequence.
module led_flasher #(
    parameter int unsigned CLK_HZ = 27_000_000,
    parameter int unsigned ON_MS  = 80,
    parameter int unsigned OFF_MS = 80
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start_i,
    input  logic [3:0] count_i,
    output logic       busy_o,
    output logic       done_o,
    output logic       out_n_o
);

    localparam int unsigned OnLim  = (CLK_HZ / 1000) * ON_MS;
    localparam int unsigned OffLim = (CLK_HZ / 1000) * OFF_MS;
    localparam int unsigned MaxLim = (OnLim > OffLim) ? OnLim : OffLim;
    localparam int unsigned TimerW = $clog2(MaxLim + 1);

    // Timer counts down to zero, so a phase of N cycles loads N-1.
    localparam logic [TimerW-1:0] OnLoad  = TimerW'(OnLim - 1);
    localparam logic [TimerW-1:0] OffLoad = TimerW'(OffLim - 1);

    typedef enum logic [1:0] {
        StIdle,
        StOn,
        StOff
    } state_e;

    state_e            state_q, state_d;
    logic [TimerW-1:0] timer_q, timer_d;
    logic [3:0]        remaining_q, remaining_d;
    logic              out_n_q, out_n_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            timer_q     <= '0;
            remaining_q <= '0;
            out_n_q     <= 1'b1;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            timer_q     <= timer_d;
            remaining_q <= remaining_d;
            out_n_q     <= out_n_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        timer_d     = timer_q;
        remaining_d = remaining_q;
        out_n_d     = out_n_q;
        busy_d      = busy_q;
        done_d      = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (start_i) begin
                    if (count_i != 4'd0) begin
                        state_d     = StOn;
                        remaining_d = count_i;
                        timer_d     = OnLoad;
                        out_n_d     = 1'b0;
                        busy_d      = 1'b1;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            StOn: begin
                if (timer_q == '0) begin
                    state_d     = StOff;
                    remaining_d = remaining_q - 4'd1;
                    timer_d     = OffLoad;
                    out_n_d     = 1'b1;
                end else begin
                    timer_d = timer_q - 1'b1;
                end
            end
            StOff: begin
                if (timer_q == '0) begin
                    if (remaining_q != 4'd0) begin
                        state_d = StOn;
                        timer_d = OnLoad;
                        out_n_d = 1'b0;
                    end else begin
                        state_d = StIdle;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end
                end else begin
                    timer_d = timer_q - 1'b1;
                end
            end
            default: begin
                state_d = StIdle;
                out_n_d = 1'b1;
                busy_d  = 1'b0;
            end
        endcase

`ifdef LED_FLASHER_RETRIG_EN
        // A start while running overrides whatever the phase logic decided.
        if (start_i && (state_q != StIdle)) begin
            if (count_i != 4'd0) begin
                state_d     = StOn;
                remaining_d = count_i;
                timer_d     = OnLoad;
                out_n_d     = 1'b0;
                busy_d      = 1'b1;
                done_d      = 1'b0;
            end else begin
                state_d     = StIdle;
                remaining_d = 4'd0;
                timer_d     = '0;
                out_n_d     = 1'b1;
                busy_d      = 1'b0;
                done_d      = 1'b1;
            end
        end
`endif
    end

    assign busy_o  = busy_q;
    assign done_o  = done_q;
    assign out_n_o = out_n_q;

endmodule

// File: tb/tb_led_flasher.sv
// Scoreboard bench for led_flasher: each request queues the expected per-sequence
// busy/flash/low-time totals, and a monitor checks them whenever done pulses.
module tb_led_flasher;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [3:0] count;
    logic       busy;
    logic       done;
    logic       out_n;

    led_flasher #(
        .CLK_HZ(1_000_000),
        .ON_MS (1),
        .OFF_MS(2)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start_i(start),
        .count_i(count),
        .busy_o (busy),
        .done_o (done),
        .out_n_o(out_n)
    );

    typedef struct {
        int busy_cycles;
        int falls;
        int low_cycles;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fails  = 0;

    int   busy_cnt  = 0;
    int   fall_cnt  = 0;
    int   low_cnt   = 0;
    logic prev_out  = 1'b1;
    logic prev_done = 1'b0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fails++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic push_exp(input int b, input int f, input int l);
        exp_t e;
        e.busy_cycles = b;
        e.falls       = f;
        e.low_cycles  = l;
        sb.push_back(e);
    endtask

    // Monitor: samples on the falling edge, away from the active edge.
    always @(negedge clk) begin
        if (!rst_n) begin
            busy_cnt  = 0;
            fall_cnt  = 0;
            low_cnt   = 0;
            prev_out  = 1'b1;
            prev_done = 1'b0;
        end else begin
            if (busy) busy_cnt++;
            if (!out_n) low_cnt++;
            if (prev_out && !out_n) fall_cnt++;
            prev_out = out_n;
            if (done) begin
                chk("done_single_cycle", int'(prev_done), 0);
                chk("busy_low_at_done", int'(busy), 0);
                n_checks++;
                if (sb.size() == 0) begin
                    n_fails++;
                    $display("FAIL unexpected_done: got done=1, expected no done (t=%0t)", $time);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("busy_cycles", busy_cnt, e.busy_cycles);
                    chk("flash_count", fall_cnt, e.falls);
                    chk("low_cycles", low_cnt, e.low_cycles);
                end
                busy_cnt = 0;
                fall_cnt = 0;
                low_cnt  = 0;
            end
            prev_done = done;
        end
    end

    // Drive start for one cycle; returns #1 after the edge that sampled it.
    task automatic pulse_start(input logic [3:0] cnt);
        @(posedge clk);
        #1;
        start = 1'b1;
        count = cnt;
        @(posedge clk);
        #1;
        start = 1'b0;
        count = 4'd0;
    endtask

    task automatic wait_sb_empty(input string name, input int limit);
        int n = 0;
        while (sb.size() != 0 && n < limit) begin
            @(posedge clk);
            n++;
        end
        chk(name, sb.size(), 0);
        repeat (4) @(posedge clk);
        #1;
    endtask

    initial begin
        bit seen;
        rst_n = 1'b0;
        start = 1'b0;
        count = 4'd0;
        #23;
        chk("reset_out_n", int'(out_n), 1);
        chk("reset_busy", int'(busy), 0);
        chk("reset_done", int'(done), 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Single flash.
        push_exp(3000, 1, 1000);
        pulse_start(4'd1);
        chk("single_latency_out_n", int'(out_n), 0);
        chk("single_latency_busy", int'(busy), 1);
        wait_sb_empty("single_timeout", 4000);

        // Three flashes.
        push_exp(9000, 3, 3000);
        pulse_start(4'd3);
        chk("three_latency_out_n", int'(out_n), 0);
        wait_sb_empty("three_timeout", 10000);

        // Zero count.
        push_exp(0, 0, 0);
        pulse_start(4'd0);
        chk("zero_done", int'(done), 1);
        chk("zero_busy", int'(busy), 0);
        chk("zero_out_n", int'(out_n), 1);
        @(posedge clk);
        #1;
        chk("zero_done_next", int'(done), 0);
        wait_sb_empty("zero_timeout", 10);

        // Start while busy at ON cycle 500.
`ifdef LED_FLASHER_RETRIG_EN
        push_exp(500 + 15000, 5, 500 + 5000);
`else
        push_exp(6000, 2, 2000);
`endif
        pulse_start(4'd2);
        repeat (498) @(posedge clk);
        pulse_start(4'd5);
        chk("busy_start_out_n", int'(out_n), 0);
        chk("busy_start_busy", int'(busy), 1);
        wait_sb_empty("busy_start_timeout", 17000);

        // Asynchronous reset during ON: no done, no queued expectation.
        pulse_start(4'd3);
        repeat (200) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("async_reset_out_n", int'(out_n), 1);
        chk("async_reset_busy", int'(busy), 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        chk("post_reset_idle_busy", int'(busy), 0);
        push_exp(3000, 1, 1000);
        pulse_start(4'd1);
        chk("post_reset_out_n", int'(out_n), 0);
        chk("post_reset_busy", int'(busy), 1);

        // Back-to-back: new start in the done cycle.
        push_exp(3000, 1, 1000);
        seen = 1'b0;
        for (int i = 0; i < 4000 && !seen; i++) begin
            @(posedge clk);
            #1;
            if (done) seen = 1'b1;
        end
        chk("b2b_done_seen", int'(seen), 1);
        start = 1'b1;
        count = 4'd1;
        @(posedge clk);
        #1;
        start = 1'b0;
        count = 4'd0;
        chk("b2b_out_n", int'(out_n), 0);
        chk("b2b_busy", int'(busy), 1);
        wait_sb_empty("b2b_timeout", 4000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/led_flasher.md
Name: led_flasher

Overview:
- Output-side counterpart to the button debouncer. It takes a one-cycle request pulse and a flash count, and drives an active-low pin as a timed sequence of ON/OFF phases measured in milliseconds.
- Sits between control logic (counter/tick domain) and a board LED or buzzer pin.
- Reports busy while running and a one-cycle done pulse when the sequence ends.

Parameters:
- CLK_HZ, 27_000_000, input clock frequency in Hz.
- ON_MS, 80, length of each ON phase in ms. ON_LIM = (CLK_HZ/1000)*ON_MS cycles; must be ≥1.
- OFF_MS, 80, length of each OFF phase in ms. OFF_LIM = (CLK_HZ/1000)*OFF_MS cycles; must be ≥1.

Ports:
- clk    input   1  system clock; all logic on rising edge.
- rst_n  input   1  asynchronous, active-low reset.
- start  input   1  request pulse, sampled on posedge clk.
- count  input   4  number of flashes, sampled with start; 0..15.
- busy   output  1  high while a sequence is running.
- done   output  1  one-cycle pulse at end of sequence.
- out_n  output  1  active-low drive; 0 = on.

Behaviour:
- Reset values: out_n=1, busy=0, done=0, state=IDLE, internal counters=0. Reset asserts asynchronously; mid-sequence it forces out_n=1 immediately and discards the sequence.
- States: IDLE, ON, OFF.
- IDLE:
  - start=1 with count≠0 → latch remaining=count, load timer, go to ON. Latency: out_n=0 and busy=1 from the first cycle after the start edge.
  - start=1 with count=0 → no flash; done=1 for one cycle on the next cycle; busy stays 0.
- ON:
  - out_n=0 for exactly ON_LIM cycles.
  - When the timer expires → OFF, decrement remaining, reload timer.
- OFF:
  - out_n=1 for exactly OFF_LIM cycles.
  - Expire with remaining≠0 → ON.
  - Expire with remaining=0 → IDLE. busy drops and done=1 in the same cycle, for one cycle.
  - The final OFF phase is always executed, so back-to-back requests stay visually separated.
- Total busy time for count=N: N*(ON_LIM+OFF_LIM) cycles.
- Timer width: $clog2(max(ON_LIM,OFF_LIM)+1). remaining width: 4 bits, no wrap, because it decrements only while nonzero.
- A start in the same cycle that done is asserted is accepted as a new sequence: busy is already 0 in that cycle.
- outputs are registered; no combinational path from start/count to any output.

Optional Feature:
- Macro: LED_FLASHER_RETRIG_EN.
- Defined: start=1 while busy (ON or OFF) restarts the sequence.
  - count≠0: reload remaining=count, reload timer, enter ON next cycle. No done pulse is issued for the aborted sequence.
  - count=0: abort to IDLE next cycle with out_n=1, busy=0, done=1.
- Not defined: start while busy is ignored entirely; the sequence continues unchanged.

Test Plan (sim parameters CLK_HZ=1_000_000, ON_MS=1, OFF_MS=2 → ON_LIM=1000, OFF_LIM=2000):
- Single flash: start=1, count=1 for one cycle.
  - out_n=0 from next cycle for exactly 1000 cycles, then 1 for 2000 cycles.
  - busy high 3000 cycles; done=1 exactly once as busy falls.
- Three flashes: start with count=3.
  - Exactly 3 falling edges on out_n, each low 1000 cycles, 2000 cycles apart.
  - busy high 9000 cycles; one done pulse.
- Zero count: start with count=0.
  - out_n stays 1, busy stays 0; done=1 on the following cycle only.
- Start while busy: count=2 running, second start with count=5 at cycle 500 of ON.
  - Macro undefined: exactly 2 flashes, done at cycle 6000.
  - Macro defined: ON restarts, then 5 flashes with 15000 busy cycles counted from the second start; single done.
- Reset mid-sequence: rst_n=0 during ON.
  - out_n=1, busy=0 without waiting for a clock edge; no done pulse.
  - After release the block is idle and accepts start (count=1) normally.
- Back-to-back: start (count=1) asserted in the done cycle.
  - New sequence begins the next cycle: out_n=0, busy=1; no idle gap.
